// File: rtl/core_fetch_queue_if.sv
// rtl/core_fetch_queue_if.sv - fetch/decode handshake bundle for core_fetch_queue
interface core_fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            i_if_valid;
   logic [XLEN-1:0] i_if_pc;
   logic [XLEN-1:0] i_if_instr;
   logic            o_if_ready;
   logic            o_id_valid;
   logic [XLEN-1:0] o_id_pc;
   logic [XLEN-1:0] o_id_instr;
   logic            i_id_ready;

   modport slave (
      input  i_if_valid, i_if_pc, i_if_instr, i_id_ready,
      output o_if_ready, o_id_valid, o_id_pc, o_id_instr
   );

   modport master (
      output i_if_valid, i_if_pc, i_if_instr, i_id_ready,
      input  o_if_ready, o_id_valid, o_id_pc, o_id_instr
   );
endinterface

// File: rtl/core_fetch_queue.sv
// rtl/core_fetch_queue.sv - in-order fetch-to-decode instruction queue with single-cycle flush
module core_fetch_queue #(
   parameter int              XLEN  = 32,
   parameter int              DEPTH = 4,
   parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_flush,
   core_fetch_queue_if.slave      bus,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] instr_mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            if_ready, id_valid, enq, deq;

   // Ready depends only on registered count, so a dequeue never frees a slot in the same cycle.
   always_comb begin
      if_ready = (count_q != FULL);
      id_valid = (count_q != '0);
      enq      = bus.i_if_valid & if_ready & ~i_flush;
      deq      = id_valid & bus.i_id_ready & ~i_flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left uncleared on reset/flush; the pointers alone define what is live.
   always_ff @(posedge i_clk) begin
      if (enq) begin
         pc_mem_q[wr_ptr_q]    <= bus.i_if_pc;
         instr_mem_q[wr_ptr_q] <= bus.i_if_instr;
      end
   end

   assign bus.o_if_ready = if_ready;
   assign bus.o_id_valid = id_valid;
   assign bus.o_id_pc    = id_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign bus.o_id_instr = id_valid ? instr_mem_q[rd_ptr_q] : NOP;
   assign o_count        = count_q;
endmodule

// File: tb/tb_core_fetch_queue.sv
// tb/tb_core_fetch_queue.sv - directed table, corner sequences and randomized model check for core_fetch_queue
module tb_core_fetch_queue;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct {
      logic        rst_n;
      logic        flush;
      logic        valid;
      logic [31:0] pc;
      logic        id_ready;
      int          exp_cnt;
      logic        exp_rdy;
      logic        exp_val;
      logic [31:0] exp_pc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [2:0] count;
   int         tests = 0;
   int         fails = 0;
   logic [31:0] mq[$];
   vec_t       tbl[$];

   core_fetch_queue_if #(.XLEN(XLEN)) bus ();

   core_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_flush (flush),
      .bus     (bus),
      .o_count (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   function automatic vec_t mk(input logic r, input logic f, input logic v, input logic [31:0] p,
                               input logic idr, input int c, input logic er, input logic ev,
                               input logic [31:0] ep);
      vec_t x;
      x.rst_n = r; x.flush = f; x.valid = v; x.pc = p; x.id_ready = idr;
      x.exp_cnt = c; x.exp_rdy = er; x.exp_val = ev; x.exp_pc = ep;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // One clock: drive at negedge, advance the queue model at posedge, compare at the next negedge.
   task automatic step(input logic r, input logic f, input logic v, input logic [31:0] p,
                       input logic idr);
      logic do_deq, do_enq;
      rst_n          = r;
      flush          = f;
      bus.i_if_valid = v;
      bus.i_if_pc    = p;
      bus.i_if_instr = instr_of(p);
      bus.i_id_ready = idr;
      do_deq = (mq.size() != 0) && idr;
      do_enq = v && (mq.size() < DEPTH);
      @(posedge clk);
      if (!r || f) mq.delete();
      else begin
         if (do_deq) void'(mq.pop_front());
         if (do_enq) mq.push_back(p);
      end
      @(negedge clk);
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_ready", 32'(bus.o_if_ready), 32'(mq.size() < DEPTH));
      chk("model_valid", 32'(bus.o_id_valid), 32'(mq.size() != 0));
      chk("model_pc", bus.o_id_pc, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("model_instr", bus.o_id_instr, (mq.size() != 0) ? instr_of(mq[0]) : NOP);
   endtask

   logic [31:0] nxt_pc, hold_pc, p;
   logic        hold, was_ready, r, f, v;

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      bus.i_if_valid = 1'b0; bus.i_if_pc = '0; bus.i_if_instr = '0; bus.i_id_ready = 1'b0;

      // reset with fetch offering
      tbl.push_back(mk(0, 0, 1, 32'h010, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 1, 32'h014, 0, 0, 1, 0, 32'h0));
      // streaming
      tbl.push_back(mk(1, 0, 1, 32'h100, 1, 1, 1, 1, 32'h100));
      tbl.push_back(mk(1, 0, 1, 32'h104, 1, 1, 1, 1, 32'h104));
      tbl.push_back(mk(1, 0, 1, 32'h108, 1, 1, 1, 1, 32'h108));
      tbl.push_back(mk(1, 0, 0, 32'h000, 1, 0, 1, 0, 32'h0));
      // fill, back-pressure, full-with-dequeue
      tbl.push_back(mk(1, 0, 1, 32'h400, 0, 1, 1, 1, 32'h400));
      tbl.push_back(mk(1, 0, 1, 32'h404, 0, 2, 1, 1, 32'h400));
      tbl.push_back(mk(1, 0, 1, 32'h408, 0, 3, 1, 1, 32'h400));
      tbl.push_back(mk(1, 0, 1, 32'h40c, 0, 4, 0, 1, 32'h400));
      tbl.push_back(mk(1, 0, 1, 32'h410, 0, 4, 0, 1, 32'h400));
      tbl.push_back(mk(1, 0, 1, 32'h410, 1, 3, 1, 1, 32'h404));
      tbl.push_back(mk(1, 0, 1, 32'h410, 0, 4, 0, 1, 32'h404));
      tbl.push_back(mk(1, 0, 1, 32'h414, 1, 3, 1, 1, 32'h408));
      tbl.push_back(mk(1, 0, 1, 32'h414, 0, 4, 0, 1, 32'h408));
      tbl.push_back(mk(1, 0, 0, 32'h000, 1, 3, 1, 1, 32'h40c));
      tbl.push_back(mk(1, 0, 0, 32'h000, 1, 2, 1, 1, 32'h410));
      tbl.push_back(mk(1, 0, 0, 32'h000, 1, 1, 1, 1, 32'h414));
      tbl.push_back(mk(1, 0, 0, 32'h000, 1, 0, 1, 0, 32'h0));
      // flush priority over both handshakes
      tbl.push_back(mk(1, 0, 1, 32'h500, 0, 1, 1, 1, 32'h500));
      tbl.push_back(mk(1, 0, 1, 32'h504, 0, 2, 1, 1, 32'h500));
      tbl.push_back(mk(1, 0, 1, 32'h508, 0, 3, 1, 1, 32'h500));
      tbl.push_back(mk(1, 1, 1, 32'h200, 1, 0, 1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 1, 32'h300, 0, 1, 1, 1, 32'h300));
      tbl.push_back(mk(1, 0, 0, 32'h000, 1, 0, 1, 0, 32'h0));

      @(negedge clk);
      foreach (tbl[i]) begin
         step(tbl[i].rst_n, tbl[i].flush, tbl[i].valid, tbl[i].pc, tbl[i].id_ready);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
         chk($sformatf("vec%0d_ready", i), 32'(bus.o_if_ready), 32'(tbl[i].exp_rdy));
         chk($sformatf("vec%0d_valid", i), 32'(bus.o_id_valid), 32'(tbl[i].exp_val));
         chk($sformatf("vec%0d_pc", i), bus.o_id_pc, tbl[i].exp_pc);
      end

      // steady occupancy of 2 across the pointer wrap
      step(1, 0, 1, 32'h600, 0);
      step(1, 0, 1, 32'h604, 0);
      chk("wrap_fill_count", 32'(count), 32'd2);
      for (int k = 0; k < 10; k++) begin
         step(1, 0, 1, 32'h608 + 32'(4 * k), 1);
         chk($sformatf("wrap%0d_count", k), 32'(count), 32'd2);
         chk($sformatf("wrap%0d_pc", k), bus.o_id_pc, 32'h604 + 32'(4 * k));
      end

      // flush while full, then no stale entry
      step(1, 0, 1, 32'h630, 0);
      step(1, 0, 1, 32'h634, 0);
      chk("full_count", 32'(count), 32'd4);
      step(1, 1, 1, 32'h700, 1);
      chk("flush_full_count", 32'(count), 32'd0);
      chk("flush_full_ready", 32'(bus.o_if_ready), 32'd1);
      chk("flush_full_instr", bus.o_id_instr, NOP);
      step(1, 0, 1, 32'h800, 0);
      chk("post_flush_pc", bus.o_id_pc, 32'h800);
      chk("post_flush_instr", bus.o_id_instr, instr_of(32'h800));

      // randomized traffic; a refused offer is held stable until taken or redirected
      nxt_pc = 32'h1000;
      hold   = 1'b0;
      hold_pc = '0;
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(0, 63) != 0);
         f = ($urandom_range(0, 15) == 0);
         if (hold) begin
            v = 1'b1;
            p = hold_pc;
         end else begin
            v = ($urandom_range(0, 9) < 7);
            p = nxt_pc;
         end
         was_ready = (mq.size() < DEPTH);
         step(r, f, v, p, ($urandom_range(0, 9) < 6));
         if (v && was_ready && r && !f) nxt_pc = nxt_pc + 32'd4;
         hold    = v && !was_ready && r && !f;
         hold_pc = p;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/core_fetch_queue.md
# core_fetch_queue

Instruction queue between the fetch stage and the decode stage. It captures each fetched {PC, instruction} pair under a valid/ready handshake and presents the oldest entry to decode in order. It back-pressures fetch through `o_if_ready`, which drives the fetch stage's PC-write enable. A branch redirect flushes every queued entry in one cycle.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.
- `DEPTH`, 4: number of queue entries; a power of two, at least 2.
- `NOP`, 32'h00000013: instruction presented when the queue is empty (`addi x0,x0,0`).

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset; synchronous, active-low.
- `i_flush`  in  1  branch redirect; discards all entries.
- `i_if_valid`  in  1  fetch offers an entry.
- `i_if_pc`  in  XLEN  PC of the offered instruction.
- `i_if_instr`  in  XLEN  offered instruction word.
- `o_if_ready`  out  1  queue accepts an entry this cycle.
- `o_id_valid`  out  1  head entry is valid.
- `o_id_pc`  out  XLEN  PC of the head entry.
- `o_id_instr`  out  XLEN  instruction of the head entry.
- `i_id_ready`  in  1  decode consumes the head this cycle.
- `o_count`  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular buffer of DEPTH entries, each {pc, instr}.
- Pointers and count:
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
  - `count` ranges 0..DEPTH.
- Enqueue: `enq = i_if_valid & o_if_ready & ~i_flush`. On enqueue:
  - write {`i_if_pc`, `i_if_instr`} at `wr_ptr`;
  - increment `wr_ptr`.
- Dequeue: `deq = o_id_valid & i_id_ready & ~i_flush`. On dequeue, increment `rd_ptr`.
- Count update:
  - enq and deq in the same cycle: count unchanged;
  - enq only: +1;
  - deq only: −1.
- `o_if_ready = (count != DEPTH)`.
  - When full, there is no bypass: a same-cycle dequeue does not open space until the next cycle.
- `o_id_valid = (count != 0)`.
- Head outputs when `o_id_valid` is 1: `o_id_pc` and `o_id_instr` are a combinational read of the entry at `rd_ptr`.
- Head outputs when `o_id_valid` is 0: `o_id_pc = 0`, `o_id_instr = NOP`.
- Flush (`i_flush = 1`):
  - next cycle: `wr_ptr = rd_ptr = count = 0`;
  - the enqueue and dequeue offered in the flush cycle are both discarded;
  - flush takes priority over all handshakes;
  - storage contents are not cleared.
- Fetch's own redirect handling is outside this block. The entry for the branch target arrives from fetch no earlier than the cycle after flush.
- Reset: same effect as flush. Storage array contents are don't-care.
- Handshake rules:
  - Fetch holds `i_if_pc` and `i_if_instr` stable while `i_if_valid & ~o_if_ready`.
  - Decode may deassert `i_id_ready` at any time.
  - Neither input depends combinationally on the queue's own outputs.
  - Both ready signals are free of combinational paths from their respective valid inputs.

## Timing
- Reset values (the cycle after `i_rst_n` is sampled low): `o_if_ready = 1`, `o_id_valid = 0`, `o_id_pc = 0`, `o_id_instr = NOP`, `o_count = 0`.
- Latency: an entry enqueued at edge N is visible on `o_id_*` after edge N. Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 entry per cycle in each direction simultaneously.
- Full boundary:
  - `o_if_ready` drops the cycle after the DEPTH-th entry is accepted;
  - it rises the cycle after the first dequeue from full.
- Empty boundary: `o_id_valid` drops the cycle after the last dequeue, unless that same edge also enqueued.
- Wrap-around: pointer increments past DEPTH−1 return to 0 with no gap or duplicate in the output stream.
- Flush while full or empty:
  - the queue is empty the following cycle;
  - `o_if_ready = 1` in that cycle.
- Reset or flush asserted mid-stream: no entry accepted before the flush edge ever appears on `o_id_*` afterwards.

## Test plan
- Reset and idle:
  - stimulus: assert `i_rst_n = 0` for 2 cycles with `i_if_valid = 1`;
  - required: `o_count = 0`, `o_id_instr = 32'h00000013`, `o_if_ready = 1`, nothing enqueued.
- In-order streaming:
  - stimulus: enqueue PCs 0x100, 0x104, 0x108 on consecutive cycles with `i_id_ready = 1` throughout;
  - required: decode sees 0x100, 0x104, 0x108 one cycle after each enqueue; `o_count` stays ≤ 1.
- Fill and back-pressure:
  - stimulus: `i_id_ready = 0`; offer 6 entries (DEPTH = 4);
  - required: only the first 4 are accepted; `o_if_ready = 0` with `o_count = 4`; the 5th is accepted only after one dequeue, in the cycle following it.
- Simultaneous enq/deq and wrap:
  - stimulus: hold `o_count = 2` and run 10 cycles of concurrent enqueue and dequeue;
  - required: `o_count` stays 2; PCs emerge strictly in order across the pointer wrap.
- Flush priority:
  - stimulus: with 3 entries queued, assert `i_flush` together with `i_if_valid = 1` (PC 0x200) and `i_id_ready = 1`;
  - required: next cycle `o_count = 0` and `o_id_valid = 0`; PC 0x200 is never output; PC 0x300 offered the following cycle is output next.
- Full-with-dequeue, no bypass:
  - stimulus: with the queue full, assert `i_id_ready = 1` and `i_if_valid = 1` in the same cycle;
  - required: the dequeue happens, the enqueue does not, and `o_count` becomes 3.
